// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Divider sequencing states, exception vectors, forward-select encoding.
package hazard_pkg;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

    localparam logic [31:0] EXC_VEC   = 32'hBFC00380;
    localparam logic [31:0] ERET_CODE = 32'h0000000E;
    localparam int          FWD_RF    = 0;

endpackage

// File: rtl/fwd_select.sv
// Priority match of one source register against the producer stages.
// The lowest-index (youngest) producer writing the source wins.
module fwd_select #(
    parameter int REG_AW = 5,
    parameter int NPROD  = 3,
    parameter int SEL_W  = 2,
    parameter int FIRST  = 0
) (
    input  logic [REG_AW-1:0]       src,
    input  logic [NPROD*REG_AW-1:0] wreg,
    input  logic [NPROD-1:0]        we,
    output logic [SEL_W-1:0]        sel
);
    import hazard_pkg::*;

    always_comb begin
        sel = SEL_W'(FWD_RF);
        for (int k = NPROD - 1; k >= FIRST; k--) begin
            if (we[k] && (src != '0) &&
                (wreg[k*REG_AW +: REG_AW] == src)) begin
                sel = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for the five-stage core: forwarding, load-use bubbles,
// divider sequencing, and exception flush/redirect with fetch hold-off.
module pipe_hazard_ctrl #(
    parameter int          REG_AW    = 5,
    parameter int          NPROD     = 3,
    parameter int          SEL_W     = $clog2(NPROD + 1),
    parameter logic [31:0] EXC_VEC   = hazard_pkg::EXC_VEC,
    parameter logic [31:0] ERET_CODE = hazard_pkg::ERET_CODE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_AW-1:0]       rs_d,
    input  logic [REG_AW-1:0]       rt_d,
    input  logic [REG_AW-1:0]       rs_e,
    input  logic [REG_AW-1:0]       rt_e,
    input  logic [NPROD*REG_AW-1:0] prod_wreg,
    input  logic [NPROD-1:0]        prod_we,
    input  logic [NPROD-1:0]        prod_load,
    output logic [SEL_W-1:0]        fwd_a_d,
    output logic [SEL_W-1:0]        fwd_b_d,
    output logic [SEL_W-1:0]        fwd_a_e,
    output logic [SEL_W-1:0]        fwd_b_e,
    input  logic                    md_op_e,
    input  logic                    md_ready,
    output logic                    md_start,
    output logic                    md_abort,
    input  logic                    stallreq_if,
    input  logic                    stallreq_mem,
    input  logic [31:0]             exc_type_m,
    input  logic [31:0]             epc_m,
    output logic                    stall_f,
    output logic                    stall_d,
    output logic                    stall_e,
    output logic                    stall_m,
    output logic                    flush_f,
    output logic                    flush_d,
    output logic                    flush_e,
    output logic                    flush_m,
    output logic                    flush_w,
    output logic                    redirect,
    output logic [31:0]             newpc
);
    import hazard_pkg::*;

    md_state_t   md_state;
    logic        exc;
    logic [31:0] exc_target;
    logic        lu_stall;
    logic        md_go;
    logic        stall_e_raw;
    logic        stall_fd_raw;
    logic        pend_v;
    logic [31:0] pend_pc;

    fwd_select #(.REG_AW(REG_AW), .NPROD(NPROD), .SEL_W(SEL_W), .FIRST(0))
    u_fwd_a_d (.src(rs_d), .wreg(prod_wreg), .we(prod_we), .sel(fwd_a_d));

    fwd_select #(.REG_AW(REG_AW), .NPROD(NPROD), .SEL_W(SEL_W), .FIRST(0))
    u_fwd_b_d (.src(rt_d), .wreg(prod_wreg), .we(prod_we), .sel(fwd_b_d));

    fwd_select #(.REG_AW(REG_AW), .NPROD(NPROD), .SEL_W(SEL_W), .FIRST(1))
    u_fwd_a_e (.src(rs_e), .wreg(prod_wreg), .we(prod_we), .sel(fwd_a_e));

    fwd_select #(.REG_AW(REG_AW), .NPROD(NPROD), .SEL_W(SEL_W), .FIRST(1))
    u_fwd_b_e (.src(rt_e), .wreg(prod_wreg), .we(prod_we), .sel(fwd_b_e));

    assign exc        = |exc_type_m;
    assign exc_target = (exc_type_m == ERET_CODE) ? epc_m : EXC_VEC;

    always_comb begin
        lu_stall = 1'b0;
        for (int k = 0; k < NPROD; k++) begin
            if (prod_we[k] && prod_load[k]) begin
                if ((rs_d != '0) && (prod_wreg[k*REG_AW +: REG_AW] == rs_d))
                    lu_stall = 1'b1;
                if ((rt_d != '0) && (prod_wreg[k*REG_AW +: REG_AW] == rt_d))
                    lu_stall = 1'b1;
            end
        end
    end

    // A divide launches only when E is actually advancing into the unit.
    assign md_go = (md_state == MD_IDLE) & md_op_e & ~stallreq_mem & ~exc;

    assign stall_e_raw  = stallreq_mem | md_go | (md_state == MD_BUSY);
    assign stall_fd_raw = stall_e_raw | lu_stall | stallreq_if;

    assign stall_m  = ~exc & stallreq_mem;
    assign stall_e  = ~exc & stall_e_raw;
    assign stall_d  = ~exc & stall_fd_raw;
    assign stall_f  = exc ? stallreq_if : stall_fd_raw;

    assign flush_f  = exc;
    assign flush_d  = exc | pend_v;
    assign flush_e  = exc | (lu_stall & ~stall_e_raw);
    assign flush_m  = exc;
    assign flush_w  = stallreq_mem;

    assign md_start = md_go & ~rst;
    assign md_abort = (md_state == MD_BUSY) & exc & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            md_state <= MD_IDLE;
        end else begin
            unique case (md_state)
                MD_IDLE: if (md_go) md_state <= MD_BUSY;
                MD_BUSY: begin
                    if (exc)           md_state <= MD_IDLE;
                    else if (md_ready) md_state <= MD_DONE;
                end
                MD_DONE: md_state <= MD_IDLE;
                default: md_state <= MD_IDLE;
            endcase
        end
    end

    // Redirect is held while fetch is stuck on the bus; newest exception wins.
    assign redirect = ~stallreq_if & (exc | pend_v);
    assign newpc    = exc ? exc_target : (pend_v ? pend_pc : EXC_VEC);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v  <= 1'b0;
            pend_pc <= '0;
        end else if (exc && stallreq_if) begin
            pend_v  <= 1'b1;
            pend_pc <= exc_target;
        end else if (!stallreq_if) begin
            pend_v  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed checks of pipe_hazard_ctrl against a
// behavioural reference model.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int NP = 3;
    localparam int SW = 2;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [AW-1:0]    rs_d, rt_d, rs_e, rt_e;
    logic [NP*AW-1:0] prod_wreg;
    logic [NP-1:0]    prod_we, prod_load;
    logic [SW-1:0]    fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
    logic             md_op_e, md_ready, md_start, md_abort;
    logic             stallreq_if, stallreq_mem;
    logic [31:0]      exc_type_m, epc_m, newpc;
    logic             stall_f, stall_d, stall_e, stall_m;
    logic             flush_f, flush_d, flush_e, flush_m, flush_w;
    logic             redirect;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .prod_wreg(prod_wreg), .prod_we(prod_we), .prod_load(prod_load),
        .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .md_op_e(md_op_e), .md_ready(md_ready),
        .md_start(md_start), .md_abort(md_abort),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
        .exc_type_m(exc_type_m), .epc_m(epc_m),
        .stall_f(stall_f), .stall_d(stall_d),
        .stall_e(stall_e), .stall_m(stall_m),
        .flush_f(flush_f), .flush_d(flush_d), .flush_e(flush_e),
        .flush_m(flush_m), .flush_w(flush_w),
        .redirect(redirect), .newpc(newpc)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          div_busy = 0;
    bit          div_done = 0;
    bit          pend     = 0;
    logic [31:0] pend_addr = '0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int fwd_ref(logic [AW-1:0] src, int first);
        for (int k = first; k < NP; k++)
            if (prod_we[k] && src != 0 && prod_wreg[k*AW +: AW] == src)
                return k + 1;
        return 0;
    endfunction

    task automatic clear_in();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        prod_wreg = 0; prod_we = 0; prod_load = 0;
        md_op_e = 0; md_ready = 0;
        stallreq_if = 0; stallreq_mem = 0;
        exc_type_m = 0; epc_m = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Compare every output with the model at mid-cycle, then advance the model.
    task automatic cyc();
        bit          exc, lu, start, e_raw, fd, rd;
        logic [31:0] tgt;
        logic [3:0]  st;
        logic [4:0]  fl;
        #4;
        if (rst) begin
            div_busy = 0; div_done = 0; pend = 0; pend_addr = 0;
            return;
        end
        exc = (exc_type_m != 0);
        tgt = (exc_type_m == 32'hE) ? epc_m : VEC;
        lu = 0;
        for (int k = 0; k < NP; k++)
            if (prod_we[k] && prod_load[k]) begin
                if (rs_d != 0 && rs_d == prod_wreg[k*AW +: AW]) lu = 1;
                if (rt_d != 0 && rt_d == prod_wreg[k*AW +: AW]) lu = 1;
            end
        start = !div_busy && !div_done && md_op_e && !stallreq_mem && !exc;
        e_raw = stallreq_mem || div_busy || start;
        fd    = e_raw || lu || stallreq_if;
        st = exc ? {stallreq_if, 3'b000} : {fd, fd, e_raw, stallreq_mem};
        fl = exc ? {4'b1111, stallreq_mem}
                 : {1'b0, pend, lu && !e_raw, 1'b0, stallreq_mem};
        rd = !stallreq_if && (exc || pend);

        chk("fwd_e", {fwd_a_e, fwd_b_e},
            {SW'(fwd_ref(rs_e, 1)), SW'(fwd_ref(rt_e, 1))});
        if (!lu)
            chk("fwd_d", {fwd_a_d, fwd_b_d},
                {SW'(fwd_ref(rs_d, 0)), SW'(fwd_ref(rt_d, 0))});
        chk("stall", {stall_f, stall_d, stall_e, stall_m}, st);
        chk("flush", {flush_f, flush_d, flush_e, flush_m, flush_w}, fl);
        chk("md", {md_start, md_abort}, {start, div_busy && exc});
        chk("redirect", redirect, rd);
        if (rd) chk("newpc", newpc, exc ? tgt : pend_addr);

        if (start) div_busy = 1;
        else if (div_busy) begin
            if (exc) div_busy = 0;
            else if (md_ready) begin div_busy = 0; div_done = 1; end
        end else div_done = 0;
        if (exc && stallreq_if) begin
            pend = 1; pend_addr = tgt;
        end else if (!stallreq_if) pend = 0;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_stall"}, {stall_f, stall_d, stall_e, stall_m}, 0);
        chk({tag, "_flush"},
            {flush_f, flush_d, flush_e, flush_m, flush_w}, 0);
        chk({tag, "_md"}, {md_start, md_abort}, 0);
        chk({tag, "_fwd"}, {fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e}, 0);
        chk({tag, "_redir"}, redirect, 0);
        chk({tag, "_newpc"}, newpc, VEC);
    endtask

    int cnt;

    initial begin
        clear_in();
        rst = 1;
        nxt();
        cyc(); nxt();
        cyc(); nxt();
        rst = 0;
        cyc();
        chk_reset_vals("reset");
        nxt();

        // forwarding priority
        rs_d = 5;
        prod_wreg = {5'd5, 5'd9, 5'd5};
        prod_we = 3'b101;
        cyc(); chk("fwd_E_W", fwd_a_d, 1); nxt();
        prod_we = 3'b100;
        cyc(); chk("fwd_W", fwd_a_d, 3); nxt();
        rs_d = 0; prod_wreg = 0; prod_we = 3'b111;
        cyc(); chk("fwd_r0", fwd_a_d, 0); nxt();
        clear_in();

        // load-use bubble
        prod_load = 3'b001; prod_we = 3'b001;
        prod_wreg = {5'd0, 5'd0, 5'd8}; rt_d = 8;
        cyc();
        chk("lu_stall_fd", {stall_f, stall_d}, 2'b11);
        chk("lu_flush_e", flush_e, 1);
        chk("lu_stall_e", stall_e, 0);
        nxt();
        clear_in();
        cyc(); chk("lu_gone", flush_e, 0); nxt();

        // 32-cycle divide
        cnt = 0;
        md_op_e = 1;
        cyc();
        chk("div_start", md_start, 1);
        if (stall_e) cnt++;
        for (int i = 1; i <= 32; i++) begin
            nxt();
            md_ready = (i == 32);
            cyc();
            if (stall_e) cnt++;
            if (md_start) chk("div_restart", md_start, 0);
        end
        chk("div_stall_cycles", cnt, 33);
        nxt();
        md_ready = 0;
        cyc();
        chk("div_done_release", stall_e, 0);
        chk("div_done_nostart", md_start, 0);
        nxt();
        md_op_e = 0;
        cyc(); nxt();

        // ERET redirect
        exc_type_m = 32'hE; epc_m = 32'h8000_1234;
        cyc();
        chk("eret_redir", redirect, 1);
        chk("eret_pc", newpc, 32'h8000_1234);
        chk("eret_flush", {flush_f, flush_d, flush_e, flush_m}, 4'hF);
        nxt();
        clear_in();

        // exception held off by fetch stall
        exc_type_m = 32'h4; stallreq_if = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_redir", redirect, 0);
            chk("hold_flush_d", flush_d, 1);
            nxt();
            exc_type_m = 0;
        end
        stallreq_if = 0;
        cyc();
        chk("pend_redir", redirect, 1);
        chk("pend_pc", newpc, VEC);
        nxt();
        cyc(); chk("pend_clear", redirect, 0); nxt();

        // exception aborts a running divide
        md_op_e = 1;
        cyc(); nxt();
        cyc(); nxt();
        exc_type_m = 32'h4;
        cyc();
        chk("abort", md_abort, 1);
        chk("abort_redir", redirect, 1);
        nxt();
        clear_in();
        cyc();
        chk("abort_once", md_abort, 0);
        chk("abort_idle", stall_e, 0);
        nxt();

        // reset in the middle of a divide
        md_op_e = 1;
        cyc(); nxt();
        cyc(); nxt();
        rst = 1; md_op_e = 0;
        cyc();
        chk("rst_no_abort", md_abort, 0);
        nxt();
        rst = 0;
        cyc();
        chk_reset_vals("rst_busy");
        nxt();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            rs_d = AW'($urandom_range(0, 3));
            rt_d = AW'($urandom_range(0, 3));
            rs_e = AW'($urandom_range(0, 3));
            rt_e = AW'($urandom_range(0, 3));
            for (int k = 0; k < NP; k++)
                prod_wreg[k*AW +: AW] = AW'($urandom_range(0, 3));
            prod_we   = NP'($urandom);
            prod_load = NP'($urandom) & NP'($urandom);
            md_op_e   = ($urandom_range(0, 3) == 0);
            md_ready  = ($urandom_range(0, 7) == 0);
            stallreq_if  = ($urandom_range(0, 3) == 0);
            stallreq_mem = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 11) == 0)
                exc_type_m = $urandom_range(0, 1) ? 32'hE
                                                  : 32'($urandom_range(1, 20));
            else
                exc_type_m = 0;
            epc_m = $urandom;
            cyc();
            nxt();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
